// File: rtl/backend_seq_nch.sv
// Mixed-signal backend controller: oversampled serial config receiver with even-parity check,
// staggered VCO / per-channel reset release and ready, live gain updates after startup.
//
//   state     | meaning
//   S_WAIT_CFG | idle, waiting for first valid config frame
//   S_DLY_VCO  | counting down to VCO reset release
//   S_DLY_CH   | counting down to release of channel r_ch
//   S_DLY_RDY  | counting down from last channel release to ready
//   S_READY    | startup complete, only gain updates remain
module backend_seq_nch #(
  parameter int NUM_CH  = 2,
  parameter int GAIN_W  = 3,
  parameter int VCO_DLY = 2,
  parameter int CH_DLY  = 10,
  parameter int RDY_DLY = 10
) (
  input  logic                       i_clk,
  input  logic                       i_resetAll,
  input  logic                       i_sclk,
  input  logic                       i_sen,
  input  logic                       i_sdin,
  output logic [NUM_CH*GAIN_W-1:0]   o_gain,
  output logic                       o_resetbvco,
  output logic [NUM_CH-1:0]          o_resetb,
  output logic                       o_ready,
  output logic                       o_cfg_err,
  output logic                       o_busy
);

  localparam int FRAME_W = NUM_CH*GAIN_W + 1;
  localparam int BCNT_W  = $clog2(FRAME_W + 2);
  localparam int MAX_A   = (VCO_DLY > CH_DLY) ? VCO_DLY : CH_DLY;
  localparam int MAX_DLY = (MAX_A > RDY_DLY) ? MAX_A : RDY_DLY;
  localparam int DLY_W   = $clog2(MAX_DLY + 1);
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    S_WAIT_CFG,
    S_DLY_VCO,
    S_DLY_CH,
    S_DLY_RDY,
    S_READY
  } state_t;

  logic [1:0]              r_sclk_sync, r_sen_sync, r_sdin_sync;
  logic                    r_sclk_d, r_sen_d;
  logic [FRAME_W-1:0]      r_sr;
  logic [BCNT_W-1:0]       r_bcnt;
  logic [NUM_CH*GAIN_W-1:0] r_gain;
  logic                    r_cfg_err;
  state_t                  r_state;
  logic [DLY_W-1:0]        r_dly;
  logic [CH_W-1:0]         r_ch;
  logic                    r_vco, r_ready, r_busy;
  logic [NUM_CH-1:0]       r_resetb;

  logic                    w_sclk_s, w_sen_s, w_sdin_s;
  logic                    w_sclk_rise, w_sen_rise, w_sen_fall, w_capture;
  logic [BCNT_W-1:0]       w_bcnt_base, w_bcnt_nxt;
  logic [FRAME_W-1:0]      w_sr_nxt;
  logic                    w_frame_ok, w_frame_bad;

  always_ff @(posedge i_clk or posedge i_resetAll) begin
    if (i_resetAll) begin
      r_sclk_sync <= '0;
      r_sen_sync  <= '0;
      r_sdin_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_sen_d     <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[0], i_sclk};
      r_sen_sync  <= {r_sen_sync[0], i_sen};
      r_sdin_sync <= {r_sdin_sync[0], i_sdin};
      r_sclk_d    <= w_sclk_s;
      r_sen_d     <= w_sen_s;
    end
  end

  assign w_sclk_s    = r_sclk_sync[1];
  assign w_sen_s     = r_sen_sync[1];
  assign w_sdin_s    = r_sdin_sync[1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_sen_rise  = w_sen_s & ~r_sen_d;
  assign w_sen_fall  = ~w_sen_s & r_sen_d;
  // A clock rise coinciding with the enable fall still belongs to the frame.
  assign w_capture   = w_sclk_rise & (w_sen_s | r_sen_d);

  always_comb begin
    w_bcnt_base = w_sen_rise ? '0 : r_bcnt;
    w_bcnt_nxt  = w_bcnt_base;
    w_sr_nxt    = r_sr;
    if (w_capture) begin
      w_sr_nxt = {r_sr[FRAME_W-2:0], w_sdin_s};
      if (w_bcnt_base != BCNT_W'(FRAME_W + 1)) w_bcnt_nxt = w_bcnt_base + 1'b1;
    end
  end

  assign w_frame_ok  = w_sen_fall & (w_bcnt_nxt == BCNT_W'(FRAME_W)) & ~(^w_sr_nxt);
  assign w_frame_bad = w_sen_fall & ~w_frame_ok;

  always_ff @(posedge i_clk or posedge i_resetAll) begin
    if (i_resetAll) begin
      r_sr      <= '0;
      r_bcnt    <= '0;
      r_gain    <= '0;
      r_cfg_err <= 1'b0;
      r_state   <= S_WAIT_CFG;
      r_dly     <= '0;
      r_ch      <= '0;
      r_vco     <= 1'b0;
      r_resetb  <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_sr      <= w_sr_nxt;
      r_bcnt    <= w_bcnt_nxt;
      r_cfg_err <= w_frame_bad;
      if (w_frame_ok) r_gain <= w_sr_nxt[FRAME_W-1:1];
      case (r_state)
        S_WAIT_CFG: begin
          r_busy <= 1'b0;
          if (w_frame_ok) begin
            r_dly   <= DLY_W'(VCO_DLY - 1);
            r_state <= S_DLY_VCO;
          end
        end
        S_DLY_VCO: begin
          r_busy <= 1'b1;
          if (r_dly == '0) begin
            r_vco   <= 1'b1;
            r_ch    <= '0;
            r_dly   <= DLY_W'(CH_DLY - 1);
            r_state <= S_DLY_CH;
          end else begin
            r_dly <= r_dly - 1'b1;
          end
        end
        S_DLY_CH: begin
          r_busy <= 1'b1;
          if (r_dly == '0) begin
            r_resetb[r_ch] <= 1'b1;
            if (r_ch == CH_W'(NUM_CH - 1)) begin
              r_dly   <= DLY_W'(RDY_DLY - 1);
              r_state <= S_DLY_RDY;
            end else begin
              r_ch  <= r_ch + 1'b1;
              r_dly <= DLY_W'(CH_DLY - 1);
            end
          end else begin
            r_dly <= r_dly - 1'b1;
          end
        end
        S_DLY_RDY: begin
          if (r_dly == '0) begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_READY;
          end else begin
            r_busy <= 1'b1;
            r_dly  <= r_dly - 1'b1;
          end
        end
        S_READY: r_busy <= 1'b0;
        default: r_state <= S_WAIT_CFG;
      endcase
    end
  end

  assign o_gain      = r_gain;
  assign o_resetbvco = r_vco;
  assign o_resetb    = r_resetb;
  assign o_ready     = r_ready;
  assign o_cfg_err   = r_cfg_err;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_backend_seq_nch.sv
// Directed bench for backend_seq_nch: default instance plus a 4-channel instance,
// both fed from the same serial pins; outputs sampled 1 time unit after each falling clock edge.
module tb_backend_seq_nch;

  logic i_clk = 1'b0, i_resetAll = 1'b1, i_sclk = 1'b0, i_sen = 1'b0, i_sdin = 1'b0;
  logic [5:0] w_gain_a;
  logic       w_vco_a, w_rdy_a, w_err_a, w_busy_a;
  logic [1:0] w_rb_a;
  logic [7:0] w_gain_b;
  logic       w_vco_b, w_rdy_b, w_err_b, w_busy_b;
  logic [3:0] w_rb_b;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int tc, t0, tseq;

  backend_seq_nch dut_a (
    .i_clk(i_clk), .i_resetAll(i_resetAll), .i_sclk(i_sclk), .i_sen(i_sen), .i_sdin(i_sdin),
    .o_gain(w_gain_a), .o_resetbvco(w_vco_a), .o_resetb(w_rb_a), .o_ready(w_rdy_a),
    .o_cfg_err(w_err_a), .o_busy(w_busy_a)
  );

  backend_seq_nch #(.NUM_CH(4), .GAIN_W(2), .VCO_DLY(1), .CH_DLY(3), .RDY_DLY(1)) dut_b (
    .i_clk(i_clk), .i_resetAll(i_resetAll), .i_sclk(i_sclk), .i_sen(i_sen), .i_sdin(i_sdin),
    .o_gain(w_gain_b), .o_resetbvco(w_vco_b), .o_resetb(w_rb_b), .o_ready(w_rdy_b),
    .o_cfg_err(w_err_b), .o_busy(w_busy_b)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Frame bits sent MSB first, 4 clk low / 4 clk high per serial clock; returns cycle of enable drop.
  task automatic send_frame(input logic [15:0] bits, input int n, output int t_chg);
    @(negedge i_clk);
    i_sen = 1'b1;
    repeat (4) @(negedge i_clk);
    for (int i = n - 1; i >= 0; i--) begin
      i_sdin = bits[i];
      repeat (4) @(negedge i_clk);
      i_sclk = 1'b1;
      repeat (4) @(negedge i_clk);
      i_sclk = 1'b0;
    end
    repeat (4) @(negedge i_clk);
    i_sen = 1'b0;
    t_chg = cyc;
  endtask

  // Observe n cycles: gain switches old->new at t_cm, cfg_err pulses at t_cm if err,
  // release sequence referenced to s0 (s0 < 0: no sequence).
  task automatic watch(input int n, input int dut, input int t_cm, input int s0,
                       input logic [7:0] g_old, input logic [7:0] g_new, input bit err);
    int vd, cd, rd, nc, r, trdy;
    logic [7:0] ag;
    logic [3:0] arb, erb;
    logic av, ardy, aerr, abusy;
    if (dut == 0) begin vd = 2; cd = 10; rd = 10; nc = 2; end
    else          begin vd = 1; cd = 3;  rd = 1;  nc = 4; end
    trdy = vd + nc*cd + rd;
    for (int i = 0; i < n; i++) begin
      #1;
      if (dut == 0) begin
        ag = {2'b00, w_gain_a}; av = w_vco_a; arb = {2'b00, w_rb_a};
        ardy = w_rdy_a; aerr = w_err_a; abusy = w_busy_a;
      end else begin
        ag = w_gain_b; av = w_vco_b; arb = w_rb_b;
        ardy = w_rdy_b; aerr = w_err_b; abusy = w_busy_b;
      end
      r = cyc - s0;
      erb = '0;
      for (int k = 0; k < nc; k++) erb[k] = (s0 >= 0) && (r >= vd + (k+1)*cd);
      check("gain",    ag,    (cyc >= t_cm) ? g_new : g_old);
      check("cfg_err", aerr,  err && (cyc == t_cm));
      check("vco",     av,    (s0 >= 0) && (r >= vd));
      check("resetb",  arb,   erb);
      check("ready",   ardy,  (s0 >= 0) && (r >= trdy));
      check("busy",    abusy, (s0 >= 0) && (r >= 1) && (r < trdy));
      @(negedge i_clk);
    end
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge i_clk);
    watch(2, 0, 0, -1, 8'h00, 8'h00, 1'b0);
    watch(1, 1, 0, -1, 8'h00, 8'h00, 1'b0);
    i_resetAll = 1'b0;
    repeat (2) @(negedge i_clk);

    // good frame from idle: full sequence
    send_frame(16'b1010110, 7, tc);
    t0 = tc + 3;
    tseq = t0;
    watch(40, 0, t0, tseq, 8'h00, 8'h2B, 1'b0);

    // live reconfiguration in READY
    send_frame(16'b0001111, 7, tc);
    watch(10, 0, tc + 3, tseq, 8'h2B, 8'h07, 1'b0);

    // short and long frames in READY are rejected
    send_frame(16'b101011, 6, tc);
    watch(10, 0, tc + 3, tseq, 8'h07, 8'h07, 1'b1);
    send_frame(16'b10101100, 8, tc);
    watch(10, 0, tc + 3, tseq, 8'h07, 8'h07, 1'b1);

    // reset, then bad parity from idle, then good frame
    i_resetAll = 1'b1;
    watch(2, 0, 0, -1, 8'h00, 8'h00, 1'b0);
    i_resetAll = 1'b0;
    send_frame(16'b1010111, 7, tc);
    watch(10, 0, tc + 3, -1, 8'h00, 8'h00, 1'b1);
    send_frame(16'b1010110, 7, tc);
    watch(40, 0, tc + 3, tc + 3, 8'h00, 8'h2B, 1'b0);

    // reset mid-sequence after VCO and ch0 release
    i_resetAll = 1'b1;
    watch(1, 0, 0, -1, 8'h00, 8'h00, 1'b0);
    i_resetAll = 1'b0;
    send_frame(16'b1010110, 7, tc);
    t0 = tc + 3;
    watch(18, 0, t0, t0, 8'h00, 8'h2B, 1'b0);
    i_resetAll = 1'b1;
    watch(2, 0, 0, -1, 8'h00, 8'h00, 1'b0);
    i_resetAll = 1'b0;
    watch(40, 0, 0, -1, 8'h00, 8'h00, 1'b0);

    // 4-channel instance: ch3..ch0 = 10,01,11,00, parity 0
    send_frame(16'b100111000, 9, tc);
    watch(20, 1, tc + 3, tc + 3, 8'h00, 8'h9C, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/backend_seq_nch.md
Name: backend_seq_nch

Overview:
Parametrised successor to the two-channel mixed-signal backend controller. It receives a framed serial configuration word carrying per-channel gain codes and an even-parity bit, and validates it. It then runs a staggered power-up sequence: VCO release, one analog channel release per channel, then ready. Everything runs in the single i_clk domain; the serial interface is oversampled, and live gain reconfiguration is supported after ready.

Parameters:
NUM_CH, 2, number of analog channels (>=1)
GAIN_W, 3, gain code width per channel (>=1)
VCO_DLY, 2, i_clk cycles from config commit to o_resetbvco rise (>=1)
CH_DLY, 10, i_clk cycles between successive releases (VCO->ch0, ch k->ch k+1) (>=1)
RDY_DLY, 10, i_clk cycles from last channel release to o_ready (>=1)
Derived: FRAME_W = NUM_CH*GAIN_W+1

Ports:
i_clk  in  1  system clock, all logic on rising edge
i_resetAll  in  1  asynchronous, active-high reset
i_sclk  in  1  serial clock, sampled as data by i_clk
i_sen  in  1  serial frame enable, active-high
i_sdin  in  1  serial data, MSB first
o_gain  out  NUM_CH*GAIN_W  gain codes; channel k in bits [k*GAIN_W +: GAIN_W]
o_resetbvco  out  1  VCO reset release (active-low reset to VCO)
o_resetb  out  NUM_CH  per-channel reset release (active-low reset to channel)
o_ready  out  1  startup complete
o_cfg_err  out  1  one-cycle pulse on rejected frame
o_busy  out  1  high while sequencing (commit to o_ready)

Behaviour:
- Reset: while i_resetAll=1, all outputs and all state are 0 immediately (async), and the FSM goes to WAIT_CFG. Reset mid-sequence or mid-frame aborts everything. After release, a new valid frame is required.
- Input sync: i_sclk, i_sen and i_sdin each pass through a 2-flop synchroniser. Edges are detected on the synced versions. Requirements: i_sclk high and low each >=3 i_clk cycles; i_sdin stable around i_sclk rise.
- Frame start: on a synced i_sen rise, clear the bit counter.
- Bit capture: on a synced i_sclk rise with synced i_sen=1:
  - shift synced i_sdin into the LSB of a FRAME_W shift register (shift left);
  - increment the counter, saturating at FRAME_W+1.
  - i_sclk edges while i_sen=0 are ignored.
- Frame layout after FRAME_W bits:
  - sr[0] = parity bit;
  - sr[FRAME_W-1:1] = gain payload, channel 0 in the lowest GAIN_W bits.
  - Even parity: XOR of all FRAME_W bits must be 0.
- Frame end (synced i_sen fall), accept case: count==FRAME_W and parity good.
  - Commit: o_gain <= payload on that same edge (call it T0).
  - If the FSM is in WAIT_CFG, it moves to DLY_VCO.
- Frame end, reject case: any other condition.
  - o_cfg_err=1 for exactly one cycle.
  - o_gain and FSM unchanged.
- FSM states: WAIT_CFG -> DLY_VCO -> DLY_CH -> DLY_RDY -> READY.
  - A single down-counter and a channel index k drive the delays.
- Absolute timing relative to T0:
  - o_resetbvco=1 at T0+VCO_DLY;
  - o_resetb[k]=1 at T0+VCO_DLY+(k+1)*CH_DLY, for k=0..NUM_CH-1, in ascending order, one bit at a time;
  - o_ready=1 at T0+VCO_DLY+NUM_CH*CH_DLY+RDY_DLY.
  - Released outputs stay 1 until reset.
- o_busy: 1 from T0+1 through the cycle before o_ready rises; 0 otherwise.
- Commit while in DLY_* or READY:
  - o_gain updates at the commit edge;
  - sequence timing is not restarted or altered;
  - no output drops.
- Reject while in DLY_* or READY: o_cfg_err pulses; sequencing continues.
- Simultaneous synced i_sen fall and i_sclk rise: the bit is captured first, then the frame is evaluated including that bit.
- Overlong frame: count saturates at FRAME_W+1 and the frame is rejected.

Test Plan:
1. Defaults, frame 1010110 (ch1=101, ch0=011, parity 0), commit at T0 -> o_gain=6'b101011 at T0; o_resetbvco rises T0+2, o_resetb[0] T0+12, o_resetb[1] T0+22, o_ready T0+32; o_busy high T0+1..T0+31; o_cfg_err never pulses.
2. Bad parity: frame 1010111 from reset -> o_cfg_err one-cycle pulse; o_gain=0, all resets and o_ready stay 0, FSM stays WAIT_CFG. A following good frame then sequences as in scenario 1.
3. Short frame (6 bits) and long frame (8 bits) -> o_cfg_err pulse each; no state change.
4. In READY, send frame 0001111 (ch0=111, ch1=000, parity 1) -> o_gain=6'b000111 at commit; o_ready, o_resetb and o_resetbvco stay 1; o_busy stays 0.
5. Assert i_resetAll at T0+15 (after VCO and ch0 release) -> all outputs 0 asynchronously. After deassert, no release without a new valid frame.
6. NUM_CH=4, GAIN_W=2, VCO_DLY=1, CH_DLY=3, RDY_DLY=1, valid 9-bit frame -> o_resetbvco at T0+1; o_resetb bits at T0+4, +7, +10, +13; o_ready at T0+14.
